id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register. Captures the decoded instruction bus from decode and drives `id_ex_bus_t` into the EX stage and the operand bypass unit.
- Owns the load-use interlock: when a younger instruction needs an LW result that bypassing cannot supply in time, it freezes fetch/decode and inserts a bubble.
- Handles EX back-pressure and flush, including a flush that arrives during an EX stall.
- Keeps saturating stall/bubble performance counters.

Parameters:
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_bus_in  in  id_ex_bus_t  decoded instruction from ID; fields rs1, rs2, rd, opcode.
- id_valid_in  in  1  id_bus_in holds a real instruction.
- ex_stall_in  in  1  EX/MEM cannot accept a new instruction (for example a cache miss); hold the register.
- flush_in  in  1  kill the instruction currently in ID (taken branch or mispredict resolved in EX).
- clear_counts_in  in  1  synchronous clear of both counters.
- id_ex_bus_out  out  id_ex_bus_t  registered bus to EX and the bypass unit.
- id_ex_valid_out  out  1  id_ex_bus_out is a real instruction.
- stall_id_out  out  1  fetch/decode must hold its current instruction this cycle.
- load_use_out  out  1  a load-use hazard was detected this cycle.
- stall_count_out  out  CNT_W  cycles with stall_id_out=1.
- bubble_count_out  out  CNT_W  bubbles inserted.

Behaviour:
- Reset (asynchronous, rst_n=0): id_ex_bus_out=all-zero, id_ex_valid_out=0, flush_pending=0, both counters=0. Combinational outputs follow from the cleared state. Reset takes effect immediately, including mid-stall or mid-flush; no pending state survives.
- Bubble: all-zero bus (opcode 0 matches none of ALUopR, ALUopI, LW, SW) with valid=0. A bubble never triggers bypass or load-use.
- Internal signal eff_flush = flush_in | flush_pending.
- load_use (combinational) = id_valid_in & id_ex_valid_out & (id_ex_bus_out.opcode==LW) & (id_ex_bus_out.rd!=0) & ~eff_flush & (hit_rs1 | hit_rs2), where:
  - hit_rs1 = (id_bus_in.rs1 == id_ex_bus_out.rd);
  - hit_rs2 = (id_bus_in.rs2 == id_ex_bus_out.rd), and it is ignored when id_bus_in.opcode is ALUopI or LW (no rs2 source).
- load_use_out = load_use. stall_id_out = ex_stall_in | load_use.
- Register update per rising edge, first matching rule wins:
  1. ex_stall_in=1: hold bus and valid. If flush_in=1, set flush_pending=1.
  2. eff_flush=1: load a bubble and clear flush_pending.
  3. load_use=1: load a bubble. ID holds its instruction, so it re-presents next cycle and then sees the LW in MEM, where WB bypass serves it.
  4. Otherwise: load id_bus_in, with valid=id_valid_in.
- Latency: 1 cycle from ID to id_ex_bus_out. A load-use costs exactly 1 bubble.
- Back-to-back: LW followed by a dependent LW stalls once. The second LW then becomes a load-use source for the next instruction.
- flush_in with id_valid_in=0 still loads a bubble (no effect on valid) and counts a bubble only when id_valid_in=1.
- Counters:
  - stall_count increments when stall_id_out=1.
  - bubble_count increments when rule 3 fires, or when rule 2 fires with id_valid_in=1.
  - Both saturate at 2^CNT_W-1 with no wrap.
  - clear_counts_in=1 zeroes both on the next edge; clear takes precedence over increment in the same cycle.
- No combinational path from id_bus_in to id_ex_bus_out. stall_id_out and load_use_out are combinational from id_bus_in, id_valid_in, ex_stall_in, flush_in, flush_pending and the register contents.

Test Plan:
- Load-use stall: register holds LW rd=5; ID presents ALUopR rs1=5 rs2=0 valid -> load_use_out=1, stall_id_out=1. Next edge: bubble (valid=0), bubble_count=1, stall_count=1. Following cycle: ALUopR is captured and load_use_out=0.
- rs2 filtering:
  - LW rd=7 in register, ID ALUopI with rs2 field=7 -> no stall, instruction captured next edge.
  - Same with ID SW rs2=7 -> stall for 1 cycle.
  - LW rd=0 in register, ID rs1=0 -> no stall.
- Flush during EX stall: ex_stall_in=1 for 3 cycles, flush_in pulsed in stall cycle 2 -> register holds for all 3 cycles. First non-stall edge loads a bubble and clears flush_pending. Next edge captures the new ID instruction. stall_count=3.
- Flush vs load-use: LW rd=3 in register, ID rs1=3, flush_in=1 same cycle -> load_use_out=0, bubble loaded, bubble_count=1, stall_count=0.
- Counter saturation and clear: CNT_W=4, force 20 load-use stalls -> stall_count_out=15 and holds there. clear_counts_in together with a stall -> counter reads 0 next cycle.
- Async reset mid-stall: rst_n low between edges while stalled with flush_pending=1 -> outputs zero immediately. After release, first valid ID instruction is captured with no stray bubble.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock, flush/back-pressure handling
// and saturating stall/bubble performance counters.
package id_ex_pkg;
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } id_ex_bus_t;

  localparam logic [6:0] ALUopR = 7'b0110011;
  localparam logic [6:0] ALUopI = 7'b0010011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
endpackage

module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  id_ex_bus_t       id_bus_in,
  input  logic             id_valid_in,
  input  logic             ex_stall_in,
  input  logic             flush_in,
  input  logic             clear_counts_in,
  output id_ex_bus_t       id_ex_bus_out,
  output logic             id_ex_valid_out,
  output logic             stall_id_out,
  output logic             load_use_out,
  output logic [CNT_W-1:0] stall_count_out,
  output logic [CNT_W-1:0] bubble_count_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  id_ex_bus_t       busR;
  logic             validR;
  logic             flushPendingR;
  logic [CNT_W-1:0] stallCountR;
  logic [CNT_W-1:0] bubbleCountR;

  logic effFlushS;
  logic usesRs2S;
  logic hitRs1S;
  logic hitRs2S;
  logic loadUseS;
  logic stallS;
  logic bubbleIncS;

  // Hazard detection against the LW currently held in the register.
  always_comb begin
    effFlushS = flush_in | flushPendingR;
    case (id_bus_in.opcode)
      ALUopI, LW: usesRs2S = 1'b0;
      default:    usesRs2S = 1'b1;
    endcase
    hitRs1S  = (id_bus_in.rs1 == busR.rd);
    hitRs2S  = usesRs2S & (id_bus_in.rs2 == busR.rd);
    loadUseS = id_valid_in & validR & (busR.opcode == LW) & (busR.rd != 5'd0)
             & ~effFlushS & (hitRs1S | hitRs2S);
    stallS   = ex_stall_in | loadUseS;
    // A flush during an EX stall is counted when it is finally applied.
    bubbleIncS = ~ex_stall_in & ((effFlushS & id_valid_in) | loadUseS);
  end

  // Pipeline register: stall holds, flush/load-use insert a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busR          <= '0;
      validR        <= 1'b0;
      flushPendingR <= 1'b0;
    end else if (ex_stall_in) begin
      busR          <= busR;
      validR        <= validR;
      flushPendingR <= flushPendingR | flush_in;
    end else if (effFlushS || loadUseS) begin
      busR          <= '0;
      validR        <= 1'b0;
      flushPendingR <= 1'b0;
    end else begin
      busR          <= id_bus_in;
      validR        <= id_valid_in;
      flushPendingR <= 1'b0;
    end
  end

  // Saturating stall counter; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCountR <= '0;
    end else if (clear_counts_in) begin
      stallCountR <= '0;
    end else if (stallS && (stallCountR != CNT_MAX)) begin
      stallCountR <= stallCountR + CNT_ONE;
    end else begin
      stallCountR <= stallCountR;
    end
  end

  // Saturating bubble counter; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubbleCountR <= '0;
    end else if (clear_counts_in) begin
      bubbleCountR <= '0;
    end else if (bubbleIncS && (bubbleCountR != CNT_MAX)) begin
      bubbleCountR <= bubbleCountR + CNT_ONE;
    end else begin
      bubbleCountR <= bubbleCountR;
    end
  end

  assign id_ex_bus_out    = busR;
  assign id_ex_valid_out  = validR;
  assign load_use_out     = loadUseS;
  assign stall_id_out     = stallS;
  assign stall_count_out  = stallCountR;
  assign bubble_count_out = bubbleCountR;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vectors with literal expectations
// plus a rule-level reference model compared every falling edge.
module tb_id_ex_stage;
  import id_ex_pkg::*;

  localparam int CNT_W = 4;
  localparam int CNT_SAT = 15;

  logic             clk = 1'b0;
  logic             rst_n;
  id_ex_bus_t       id_bus_in;
  logic             id_valid_in;
  logic             ex_stall_in;
  logic             flush_in;
  logic             clear_counts_in;
  id_ex_bus_t       id_ex_bus_out;
  logic             id_ex_valid_out;
  logic             stall_id_out;
  logic             load_use_out;
  logic [CNT_W-1:0] stall_count_out;
  logic [CNT_W-1:0] bubble_count_out;

  int checks = 0;
  int failures = 0;

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_bus_in(id_bus_in), .id_valid_in(id_valid_in),
    .ex_stall_in(ex_stall_in), .flush_in(flush_in), .clear_counts_in(clear_counts_in),
    .id_ex_bus_out(id_ex_bus_out), .id_ex_valid_out(id_ex_valid_out),
    .stall_id_out(stall_id_out), .load_use_out(load_use_out),
    .stall_count_out(stall_count_out), .bubble_count_out(bubble_count_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural view of the stage.
  id_ex_bus_t mBus;
  logic       mValid;
  logic       mPend;
  int         mStall;
  int         mBubble;

  function automatic logic readsReg(input id_ex_bus_t ins, input logic [4:0] r);
    logic hasRs2;
    hasRs2 = !(ins.opcode == ALUopI || ins.opcode == LW);
    return (r != 5'd0) && (ins.rs1 == r || (hasRs2 && ins.rs2 == r));
  endfunction

  function automatic logic expLoadUse();
    return id_valid_in && mValid && mBus.opcode == LW && readsReg(id_bus_in, mBus.rd)
           && !(flush_in || mPend);
  endfunction

  function automatic int satInc(input int v, input logic inc);
    return (inc && v < CNT_SAT) ? v + 1 : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mBus <= '0; mValid <= 1'b0; mPend <= 1'b0; mStall <= 0; mBubble <= 0;
    end else begin
      logic bub;
      bub = 1'b0;
      if (ex_stall_in) begin
        if (flush_in) mPend <= 1'b1;
      end else if (flush_in || mPend) begin
        mBus <= '0; mValid <= 1'b0; mPend <= 1'b0; bub = id_valid_in;
      end else if (expLoadUse()) begin
        mBus <= '0; mValid <= 1'b0; bub = 1'b1;
      end else begin
        mBus <= id_bus_in; mValid <= id_valid_in;
      end
      mStall  <= clear_counts_in ? 0 : satInc(mStall, ex_stall_in || expLoadUse());
      mBubble <= clear_counts_in ? 0 : satInc(mBubble, bub);
    end
  end

  // Compare all outputs against the model away from the active edge.
  always @(negedge clk) begin
    chk("m_bus", id_ex_bus_out, mBus);
    chk("m_valid", id_ex_valid_out, mValid);
    chk("m_load_use", load_use_out, expLoadUse());
    chk("m_stall_id", stall_id_out, ex_stall_in || expLoadUse());
    chk("m_stall_cnt", stall_count_out, mStall);
    chk("m_bubble_cnt", bubble_count_out, mBubble);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic v);
    id_bus_in.opcode = op; id_bus_in.rd = rd; id_bus_in.rs1 = rs1; id_bus_in.rs2 = rs2;
    id_valid_in = v;
  endtask

  initial begin
    rst_n = 1'b0; ex_stall_in = 1'b0; flush_in = 1'b0; clear_counts_in = 1'b0;
    present(7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (2) step();
    chk("rst_bus", id_ex_bus_out, 32'd0);
    chk("rst_valid", id_ex_valid_out, 32'd0);
    chk("rst_cnt", {stall_count_out, bubble_count_out}, 32'd0);
    rst_n = 1'b1;

    // Load-use stall costs one bubble
    present(LW, 5'd5, 5'd1, 5'd0, 1'b1);
    step();
    present(ALUopR, 5'd6, 5'd5, 5'd0, 1'b1);
    #1;
    chk("lu_detect", load_use_out, 32'd1);
    chk("lu_stall", stall_id_out, 32'd1);
    step();
    chk("lu_bubble_valid", id_ex_valid_out, 32'd0);
    chk("lu_bubble_cnt", bubble_count_out, 32'd1);
    chk("lu_stall_cnt", stall_count_out, 32'd1);
    #1;
    chk("lu_release", load_use_out, 32'd0);
    step();
    chk("lu_capture_op", id_ex_bus_out.opcode, ALUopR);
    chk("lu_capture_valid", id_ex_valid_out, 32'd1);
    present(7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    clear_counts_in = 1'b1;
    step();
    clear_counts_in = 1'b0;

    // rs2 filtering
    present(LW, 5'd7, 5'd1, 5'd0, 1'b1);
    step();
    present(ALUopI, 5'd8, 5'd1, 5'd7, 1'b1);
    #1;
    chk("alui_rs2_ignored", load_use_out, 32'd0);
    step();
    chk("alui_capture_rd", id_ex_bus_out.rd, 32'd8);
    present(LW, 5'd7, 5'd2, 5'd0, 1'b1);
    step();
    present(SW, 5'd0, 5'd2, 5'd7, 1'b1);
    #1;
    chk("sw_rs2_stall", stall_id_out, 32'd1);
    step();
    chk("sw_bubble", id_ex_valid_out, 32'd0);
    step();
    chk("sw_capture_op", id_ex_bus_out.opcode, SW);
    present(LW, 5'd0, 5'd2, 5'd0, 1'b1);
    step();
    present(ALUopR, 5'd1, 5'd0, 5'd0, 1'b1);
    #1;
    chk("rd0_no_stall", stall_id_out, 32'd0);
    step();

    // Flush arriving during an EX stall
    present(ALUopR, 5'd10, 5'd1, 5'd2, 1'b1);
    clear_counts_in = 1'b1;
    step();
    clear_counts_in = 1'b0;
    present(ALUopR, 5'd9, 5'd1, 5'd2, 1'b1);
    ex_stall_in = 1'b1;
    step();
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    step();
    chk("exs_hold_rd", id_ex_bus_out.rd, 32'd10);
    chk("exs_hold_valid", id_ex_valid_out, 32'd1);
    chk("exs_stall_cnt", stall_count_out, 32'd3);
    ex_stall_in = 1'b0;
    step();
    chk("exs_flush_bubble", id_ex_valid_out, 32'd0);
    chk("exs_bubble_cnt", bubble_count_out, 32'd1);
    step();
    chk("exs_capture_rd", id_ex_bus_out.rd, 32'd9);
    chk("exs_stall_cnt2", stall_count_out, 32'd3);

    // Flush beats load-use
    present(LW, 5'd3, 5'd1, 5'd0, 1'b1);
    clear_counts_in = 1'b1;
    step();
    clear_counts_in = 1'b0;
    present(ALUopR, 5'd4, 5'd3, 5'd0, 1'b1);
    flush_in = 1'b1;
    #1;
    chk("fl_no_lu", load_use_out, 32'd0);
    step();
    flush_in = 1'b0;
    chk("fl_bubble", id_ex_valid_out, 32'd0);
    chk("fl_bubble_cnt", bubble_count_out, 32'd1);
    chk("fl_stall_cnt", stall_count_out, 32'd0);

    // Saturation and clear-with-stall
    for (int i = 0; i < 20; i++) begin
      present(LW, 5'd4, 5'd0, 5'd0, 1'b1);
      step();
      present(ALUopR, 5'd5, 5'd4, 5'd0, 1'b1);
      step();
    end
    chk("sat_stall", stall_count_out, 32'd15);
    chk("sat_bubble", bubble_count_out, 32'd15);
    present(LW, 5'd4, 5'd0, 5'd0, 1'b1);
    step();
    present(ALUopR, 5'd5, 5'd4, 5'd0, 1'b1);
    clear_counts_in = 1'b1;
    #1;
    chk("clr_stall_active", stall_id_out, 32'd1);
    step();
    clear_counts_in = 1'b0;
    chk("clr_stall_cnt", stall_count_out, 32'd0);
    chk("clr_bubble_cnt", bubble_count_out, 32'd0);

    // Async reset mid-stall with a pending flush
    present(ALUopR, 5'd12, 5'd1, 5'd2, 1'b1);
    step();
    ex_stall_in = 1'b1;
    flush_in = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_bus", id_ex_bus_out, 32'd0);
    chk("arst_valid", id_ex_valid_out, 32'd0);
    chk("arst_cnt", {stall_count_out, bubble_count_out}, 32'd0);
    ex_stall_in = 1'b0;
    flush_in = 1'b0;
    present(ALUopR, 5'd11, 5'd1, 5'd2, 1'b1);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_capture_rd", id_ex_bus_out.rd, 32'd11);
    chk("arst_capture_valid", id_ex_valid_out, 32'd1);
    chk("arst_no_bubble", bubble_count_out, 32'd0);
    present(7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
